// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of a single ROM read port between NUM_REQ
// requesters. One transaction is in flight at a time: IDLE accepts, ISSUE
// drives the ROM until it acknowledges (or the watchdog fires), and RESP
// presents the registered word to the granted requester.

// Protocol checker, instantiated by the arbiter; holds only assertions.
module rom_arbiter_chk #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8
) (
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_REQ-1:0] req_ready,
    input logic [NUM_REQ-1:0] resp_valid,
    input logic               source_valid,
    input logic               in_issue,
    input logic [ADDR_W-1:0]  source_address
);
    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready))
        else $error("req_ready has more than one bit set");

    a_resp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(resp_valid))
        else $error("resp_valid has more than one bit set");

    a_source_valid_issue: assert property (@(posedge clk) disable iff (!rst_n)
        source_valid == in_issue)
        else $error("source_valid does not track the ISSUE state");

    a_source_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (source_valid && $past(source_valid)) |-> $stable(source_address))
        else $error("source_address changed during ISSUE");
endmodule

module rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [ADDR_W-1:0]         source_address,
    output logic                      source_valid,
    input  logic [DATA_W-1:0]         source_data,
    input  logic                      source_ready,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // Round-robin pick: first valid requester strictly after the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found_s && req_valid[idx]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the IDLE/ISSUE/RESP transaction sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    req_ready_s[pick_s] = 1'b1;
                    addr_d  = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    gnt_d   = pick_s;
                    ptr_d   = pick_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A ROM acknowledge on the last allowed cycle still wins over the abort.
                if (source_ready) begin
                    data_d  = source_data;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready[gnt_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and transaction registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from the registered state; every output idles at zero.
    always_comb begin
        resp_valid     = '0;
        resp_data      = '0;
        resp_err       = 1'b0;
        source_valid   = 1'b0;
        source_address = '0;
        case (state_q)
            ST_ISSUE: begin
                source_valid   = 1'b1;
                source_address = addr_q;
            end
            ST_RESP: begin
                resp_valid[gnt_q] = 1'b1;
                resp_data         = data_q;
                resp_err          = err_q;
            end
            default: begin
                source_valid = 1'b0;
            end
        endcase
    end

    // The accept pulse is combinational, so force it low while reset is held.
    assign req_ready = rst_n ? req_ready_s : '0;
    assign busy      = (state_q != ST_IDLE);

    rom_arbiter_chk #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .source_valid   (source_valid),
        .in_issue       (state_q == ST_ISSUE),
        .source_address (source_address)
    );
endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter (2 requesters, 8-bit address, 32-bit data, TIMEOUT=16).
module tb_rom_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [ADDR_W-1:0]         source_address;
    logic                      source_valid;
    logic [DATA_W-1:0]         source_data;
    logic                      source_ready;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;
    int last_g;          // reference model: last requester granted
    int rom_delay;       // ROM acknowledges after this many ISSUE cycles; <0 never
    int vcnt = 0;        // consecutive cycles source_valid has been high

    typedef struct {
        logic [1:0] rv;
        logic [7:0] a0;
        logic [7:0] a1;
        int         exp_g;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .resp_ready     (resp_ready),
        .source_address (source_address),
        .source_valid   (source_valid),
        .source_data    (source_data),
        .source_ready   (source_ready),
        .busy           (busy)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (a == 8'h05) return 32'hDEADBEEF;
        return {a ^ 8'h5A, ~a, a + 8'h11, a};
    endfunction

    // ROM model: data is a pure function of address, ready after a programmable wait.
    assign source_data  = rom_word(source_address);
    assign source_ready = source_valid && (rom_delay >= 0) && (vcnt == rom_delay);

    // Count how long the current ROM request has been outstanding.
    always @(posedge clk) vcnt <= source_valid ? vcnt + 1 : 0;

    // Reference arbitration: scan requesters in rotation after the last winner.
    function automatic int predict(input logic [1:0] rv);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last_g + k) % NUM_REQ;
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One complete transaction: request, ROM wait, response with optional backpressure.
    task automatic txn(input logic [1:0] rv, input logic [7:0] a0, input logic [7:0] a1,
                       input int delay, input int hold, input logic [1:0] bg,
                       input int exp_g, input string tag);
        logic [1:0]  eg;
        logic [7:0]  ea;
        logic [31:0] ed;
        logic        ee;
        int          exp_issue, issue_n, wait_n;
        bit          addr_ok, rdy_ok, stable_ok;
        eg = (exp_g < 0) ? 2'b00 : 2'(1 << exp_g);
        @(posedge clk); #1;
        req_valid = rv; req_addr = {a1, a0}; rom_delay = delay;
        resp_ready = (hold == 0) ? eg : 2'b00;
        @(negedge clk);
        check({tag, " accept"}, 64'(req_ready), 64'(eg));
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        req_valid = bg;
        if (exp_g < 0) begin
            @(negedge clk);
            check({tag, " stays idle"}, 64'({busy, req_ready}), 64'd0);
        end else begin
            last_g = exp_g;
            ea = (exp_g == 0) ? a0 : a1;
            if (delay < 0 || delay >= TIMEOUT) begin
                exp_issue = TIMEOUT; ed = 32'd0; ee = 1'b1;
            end else begin
                exp_issue = delay + 1; ed = rom_word(ea); ee = 1'b0;
            end
            issue_n = 0; wait_n = 0; addr_ok = 1'b1; rdy_ok = 1'b1;
            @(negedge clk);
            while (resp_valid == 2'b00 && wait_n < 64) begin
                if (source_valid) begin
                    issue_n++;
                    if (source_address !== ea) addr_ok = 1'b0;
                end
                if (req_ready !== 2'b00) rdy_ok = 1'b0;
                wait_n++;
                @(negedge clk);
            end
            check({tag, " issue cycles"}, 64'(issue_n), 64'(exp_issue));
            check({tag, " resp latency"}, 64'(wait_n), 64'(exp_issue));
            check({tag, " addr held"}, 64'(addr_ok), 64'd1);
            check({tag, " no accept in issue"}, 64'(rdy_ok), 64'd1);
            check({tag, " resp_valid"}, 64'(resp_valid), 64'(eg));
            check({tag, " resp_data"}, 64'(resp_data), 64'(ed));
            check({tag, " resp_err"}, 64'(resp_err), 64'(ee));
            if (hold > 0) begin
                stable_ok = 1'b1;
                for (int h = 1; h < hold; h++) begin
                    @(negedge clk);
                    if (resp_valid !== eg || resp_data !== ed || resp_err !== ee || req_ready !== 2'b00)
                        stable_ok = 1'b0;
                end
                @(posedge clk); #1;
                resp_ready = eg;
                @(negedge clk);
                if (resp_valid !== eg || resp_data !== ed || req_ready !== 2'b00) stable_ok = 1'b0;
                check({tag, " resp stable"}, 64'(stable_ok), 64'd1);
            end
            @(posedge clk); #1;
            resp_ready = 2'b00;
            @(negedge clk);
            check({tag, " back to idle"}, 64'({busy, resp_valid, resp_err, resp_data}), 64'd0);
        end
    endtask

    // Wait for an already-accepted transaction and release it.
    task automatic drain(input logic [1:0] eg, input logic [31:0] ed, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 2'b00; resp_ready = eg;
        @(negedge clk);
        while (resp_valid == 2'b00 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({tag, " resp_valid"}, 64'(resp_valid), 64'(eg));
        check({tag, " resp_data"}, 64'(resp_data), 64'(ed));
        @(posedge clk); #1;
        resp_ready = 2'b00;
        @(negedge clk);
        check({tag, " back to idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit quiet_ok;
        tbl[0] = '{2'b11, 8'h10, 8'h20, 0};
        tbl[1] = '{2'b11, 8'h10, 8'h20, 1};
        tbl[2] = '{2'b11, 8'h10, 8'h20, 0};
        tbl[3] = '{2'b11, 8'h10, 8'h20, 1};
        tbl[4] = '{2'b01, 8'h05, 8'h00, 0};
        tbl[5] = '{2'b10, 8'h00, 8'h3C, 1};
        tbl[6] = '{2'b10, 8'h00, 8'hC3, 1};
        tbl[7] = '{2'b01, 8'hFF, 8'h00, 0};
        tbl[8] = '{2'b00, 8'h12, 8'h34, -1};

        rst_n = 1'b0; req_valid = 2'b01; req_addr = '0; resp_ready = 2'b00;
        rom_delay = 0; last_g = NUM_REQ - 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs",
              64'({req_ready, resp_valid, resp_err, source_valid, busy, source_address, resp_data}), 64'd0);
        req_valid = 2'b00;
        #2 rst_n = 1'b1;

        // Table vectors: single request, alternating contention, idle.
        for (int v = 0; v < 9; v++)
            txn(tbl[v].rv, tbl[v].a0, tbl[v].a1, 0, 0, 2'b00, tbl[v].exp_g, $sformatf("vec%0d", v));

        // Slow ROM, and an acknowledge on the very last watchdog cycle.
        txn(2'b10, 8'h00, 8'h77, 3, 0, 2'b00, predict(2'b10), "slow rom");
        txn(2'b01, 8'h42, 8'h00, TIMEOUT - 1, 0, 2'b00, predict(2'b01), "late ack");

        // Watchdog abort, then a normal transaction.
        txn(2'b01, 8'h66, 8'h00, -1, 0, 2'b00, predict(2'b01), "timeout");
        txn(2'b11, 8'h01, 8'h02, 0, 0, 2'b00, predict(2'b11), "after timeout");

        // Response backpressure with requester 1 waiting.
        txn(2'b01, 8'h44, 8'h55, 0, 5, 2'b10, predict(2'b01), "backpressure");
        check("bp late accept", 64'(req_ready), 64'(2'b10));
        last_g = 1;
        drain(2'b10, rom_word(8'h55), "bp req1");

        // Reset in the middle of ISSUE.
        @(posedge clk); #1;
        req_valid = 2'b01; req_addr = {8'h99, 8'h88}; rom_delay = -1;
        @(negedge clk);
        check("rst accept", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #2;
        check("rst in issue", 64'(source_valid), 64'd1);
        rst_n = 1'b0; req_valid = 2'b11;
        #1;
        check("rst async outputs",
              64'({req_ready, resp_valid, resp_err, source_valid, busy, source_address, resp_data}), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        req_valid = 2'b00; rom_delay = 0; rst_n = 1'b1; last_g = NUM_REQ - 1;
        quiet_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 2'b00 || busy !== 1'b0) quiet_ok = 1'b0;
        end
        check("no stale response", 64'(quiet_ok), 64'd1);
        txn(2'b10, 8'h00, 8'hAB, 0, 0, 2'b00, predict(2'b10), "post reset");

        // Randomised transactions against the reference model.
        for (int r = 0; r < 50; r++) begin
            logic [1:0] rv;
            logic [7:0] a0, a1;
            rv = 2'($urandom_range(0, 3));
            a0 = 8'($urandom);
            a1 = 8'($urandom);
            txn(rv, a0, a1, $urandom_range(0, 3), $urandom_range(0, 3), 2'b00,
                predict(rv), $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=running expected=finished");
        $fatal(1, "time limit exceeded");
    end
endmodule
